// File: rtl/sd_dat_rx.sv
// SD data-line receive path: start-bit detect, deserialise into 32-bit words, per-line CRC16 and end-bit check.
// Optional SD_DAT_RX_1BIT_EN adds bus_width_4_i for 1-bit (DAT0-only) reception.
module sd_dat_rx #(
    parameter int BlockSizeWidth = 12,
    parameter int TimeoutWidth   = 24
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      sample_en_i,
    input  logic [3:0]                dat_i,
    input  logic                      start_i,
    input  logic [BlockSizeWidth-1:0] block_size_i,
    input  logic [TimeoutWidth-1:0]   timeout_i,
`ifdef SD_DAT_RX_1BIT_EN
    input  logic                      bus_width_4_i,
`endif
    input  logic                      full_i,
    output logic                      push_o,
    output logic [31:0]               push_data_o,
    output logic                      busy_o,
    output logic                      done_o,
    output logic                      crc_error_o,
    output logic                      end_bit_error_o,
    output logic                      timeout_error_o,
    output logic                      overrun_error_o
);
    typedef enum logic [2:0] {IDLE, WAIT_START, DATA, CRC, END, DONE} state_e;

    state_e                    state_q;
    logic [BlockSizeWidth-1:0] size_q, byte_cnt_q;
    logic [TimeoutWidth-1:0]   timeout_q;
    logic [3:0]                bit_cnt_q;
    logic [7:0]                byte_q;
    logic [31:0]               word_q;
    logic                      pend_q, wide_q;
    logic [3:0][15:0]          crc_q, rx_crc_q;
    logic                      busy_q, done_q, crc_err_q, end_err_q, to_err_q, ovr_err_q;

    logic [7:0]       byte_d;
    logic             byte_done_d, start_bit_d, end_bad_d, last_byte_d, crc_ok_d;
    logic [31:0]      word_d;
    logic [3:0]       line_en_d;
    logic [3:0][15:0] crc_d, rx_crc_d;

    always_comb begin
        line_en_d   = wide_q ? 4'hF : 4'h1;
        start_bit_d = wide_q ? (dat_i == 4'h0) : ~dat_i[0];
        end_bad_d   = wide_q ? (dat_i != 4'hF) : ~dat_i[0];
        if (wide_q) begin
            byte_d      = {byte_q[3:0], dat_i};
            byte_done_d = bit_cnt_q[0];
        end else begin
            byte_d      = {byte_q[6:0], dat_i[0]};
            byte_done_d = (bit_cnt_q[2:0] == 3'd7);
        end
        last_byte_d = (byte_cnt_q == size_q - 1'b1);
        // Little-endian packing: byte N of the block lands in lane N mod 4.
        word_d = word_q;
        word_d[{byte_cnt_q[1:0], 3'b000} +: 8] = byte_d;
        crc_ok_d = 1'b1;
        for (int l = 0; l < 4; l++) begin
            crc_d[l]    = {crc_q[l][14:0], 1'b0} ^ ({16{crc_q[l][15] ^ dat_i[l]}} & 16'h1021);
            rx_crc_d[l] = {rx_crc_q[l][14:0], dat_i[l]};
            if (line_en_d[l] && (rx_crc_d[l] != crc_q[l])) begin
                crc_ok_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            size_q     <= '0;
            byte_cnt_q <= '0;
            timeout_q  <= '0;
            bit_cnt_q  <= '0;
            byte_q     <= '0;
            word_q     <= '0;
            pend_q     <= 1'b0;
            wide_q     <= 1'b1;
            crc_q      <= '0;
            rx_crc_q   <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            crc_err_q  <= 1'b0;
            end_err_q  <= 1'b0;
            to_err_q   <= 1'b0;
            ovr_err_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            // A completed word is offered for exactly one cycle; if the buffer is full it is lost.
            if (pend_q) begin
                pend_q <= 1'b0;
                word_q <= '0;
                if (full_i) ovr_err_q <= 1'b1;
            end
            case (state_q)
                IDLE: if (start_i) begin
                    crc_err_q <= 1'b0;
                    end_err_q <= 1'b0;
                    to_err_q  <= 1'b0;
                    ovr_err_q <= 1'b0;
                    size_q    <= block_size_i;
                    timeout_q <= timeout_i;
`ifdef SD_DAT_RX_1BIT_EN
                    wide_q    <= bus_width_4_i;
`else
                    wide_q    <= 1'b1;
`endif
                    if (block_size_i == '0) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end else begin
                        busy_q  <= 1'b1;
                        state_q <= WAIT_START;
                    end
                end
                WAIT_START: if (sample_en_i) begin
                    if (start_bit_d) begin
                        state_q    <= DATA;
                        byte_cnt_q <= '0;
                        bit_cnt_q  <= '0;
                        word_q     <= '0;
                        crc_q      <= '0;
                        rx_crc_q   <= '0;
                    end else if (timeout_q <= TimeoutWidth'(1)) begin
                        to_err_q <= 1'b1;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        state_q  <= DONE;
                    end else begin
                        timeout_q <= timeout_q - 1'b1;
                    end
                end
                DATA: if (sample_en_i) begin
                    for (int l = 0; l < 4; l++) begin
                        if (line_en_d[l]) crc_q[l] <= crc_d[l];
                    end
                    byte_q    <= byte_d;
                    bit_cnt_q <= byte_done_d ? 4'd0 : bit_cnt_q + 1'b1;
                    if (byte_done_d) begin
                        word_q     <= word_d;
                        byte_cnt_q <= byte_cnt_q + 1'b1;
                        if (byte_cnt_q[1:0] == 2'd3 || last_byte_d) pend_q <= 1'b1;
                        if (last_byte_d) state_q <= CRC;
                    end
                end
                CRC: if (sample_en_i) begin
                    rx_crc_q  <= rx_crc_d;
                    bit_cnt_q <= bit_cnt_q + 1'b1;
                    if (bit_cnt_q == 4'd15) begin
                        if (!crc_ok_d) crc_err_q <= 1'b1;
                        state_q <= END;
                    end
                end
                END: if (sample_en_i) begin
                    if (end_bad_d) end_err_q <= 1'b1;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= DONE;
                end
                DONE: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign push_o          = pend_q & ~full_i;
    assign push_data_o     = word_q;
    assign busy_o          = busy_q;
    assign done_o          = done_q;
    assign crc_error_o     = crc_err_q;
    assign end_bit_error_o = end_err_q;
    assign timeout_error_o = to_err_q;
    assign overrun_error_o = ovr_err_q;
endmodule

// File: tb/tb_sd_dat_rx.sv
// Self-checking bench for sd_dat_rx: a byte-array model gives expected words and per-line CRC16 values.
module tb_sd_dat_rx;
    localparam int BW = 12;
    localparam int TW = 24;

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic          sample_en_i = 1'b0;
    logic [3:0]    dat_i = 4'hF;
    logic          start_i = 1'b0;
    logic [BW-1:0] block_size_i = '0;
    logic [TW-1:0] timeout_i = '0;
    logic          full_i = 1'b0;
`ifdef SD_DAT_RX_1BIT_EN
    logic          bus_width_4_i = 1'b1;
`endif
    logic          push_o, busy_o, done_o;
    logic [31:0]   push_data_o;
    logic          crc_error_o, end_bit_error_o, timeout_error_o, overrun_error_o;

    int checks = 0;
    int errors = 0;
    logic [7:0]  blk [2048];
    logic [31:0] got_q [$];
    int done_cnt = 0;

    sd_dat_rx #(.BlockSizeWidth(BW), .TimeoutWidth(TW)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .sample_en_i(sample_en_i), .dat_i(dat_i),
        .start_i(start_i), .block_size_i(block_size_i), .timeout_i(timeout_i),
`ifdef SD_DAT_RX_1BIT_EN
        .bus_width_4_i(bus_width_4_i),
`endif
        .full_i(full_i), .push_o(push_o), .push_data_o(push_data_o), .busy_o(busy_o),
        .done_o(done_o), .crc_error_o(crc_error_o), .end_bit_error_o(end_bit_error_o),
        .timeout_error_o(timeout_error_o), .overrun_error_o(overrun_error_o)
    );

    always #5 clk_i = ~clk_i;

    always @(negedge clk_i) begin
        if (push_o) got_q.push_back(push_data_o);
        if (done_o) done_cnt++;
    end

    // Serial CRC16 (x^16+x^12+x^5+1, init 0) over the bit stream a given line carries.
    function automatic logic [15:0] crc_line(input int n, input int line, input bit wide);
        logic [15:0] c = 16'h0;
        logic b;
        for (int i = 0; i < n; i++) begin
            for (int k = 7; k >= 0; k--) begin
                if (wide ? (k % 4 == line) : (line == 0)) begin
                    b = blk[i][k] ^ c[15];
                    c = {c[14:0], 1'b0} ^ (b ? 16'h1021 : 16'h0000);
                end
            end
        end
        return c;
    endfunction

    task automatic strobe(input logic [3:0] d);
        @(posedge clk_i); #1;
        sample_en_i = 1'b1;
        dat_i = d;
        @(posedge clk_i); #1;
        sample_en_i = 1'b0;
        @(posedge clk_i); #1;
    endtask

    task automatic start_block(input int n, input bit wide, input int tmo);
        got_q.delete();
        done_cnt = 0;
        @(posedge clk_i); #1;
        start_i = 1'b1;
        block_size_i = BW'(n);
        timeout_i = TW'(tmo);
`ifdef SD_DAT_RX_1BIT_EN
        bus_width_4_i = wide;
`endif
        @(posedge clk_i); #1;
        start_i = 1'b0;
    endtask

    task automatic run_block(input int n, input bit wide, input logic [3:0] crc_flip,
                             input logic [3:0] end_nib, input bit full_2nd);
        logic [15:0] c [4];
        logic [3:0]  nib;
        for (int l = 0; l < 4; l++) c[l] = crc_line(n, l, wide);
        start_block(n, wide, 1000);
        strobe(4'hF);
        strobe(wide ? 4'h0 : 4'hE);
        for (int i = 0; i < n; i++) begin
            if (full_2nd && i == 4) full_i = 1'b1;
            if (wide) begin
                strobe(blk[i][7:4]);
                strobe(blk[i][3:0]);
            end else begin
                for (int k = 7; k >= 0; k--) strobe({3'b111, blk[i][k]});
            end
        end
        full_i = 1'b0;
        for (int b = 15; b >= 0; b--) begin
            nib = wide ? {c[3][b], c[2][b], c[1][b], c[0][b]} : {3'b111, c[0][b]};
            if (b == 0) nib = nib ^ crc_flip;
            strobe(nib);
        end
        strobe(end_nib);
        for (int t = 0; t < 20 && done_cnt == 0; t++) @(posedge clk_i);
        #1;
    endtask

    task automatic check_words(input string name, input int n);
        logic [31:0] w;
        checks++;
        if (got_q.size() !== (n + 3) / 4) begin
            errors++;
            $display("FAIL %s push_count got=%0d exp=%0d", name, got_q.size(), (n + 3) / 4);
        end
        for (int wi = 0; wi < (n + 3) / 4 && wi < got_q.size(); wi++) begin
            w = 32'h0;
            for (int k = 0; k < 4; k++) if (4 * wi + k < n) w[8*k +: 8] = blk[4*wi + k];
            checks++;
            if (got_q[wi] !== w) begin
                errors++;
                $display("FAIL %s word%0d got=%08h exp=%08h", name, wi, got_q[wi], w);
            end
        end
    endtask

    task automatic check_status(input string name, input int dn, input logic [3:0] errs);
        logic [3:0] obs;
        obs = {crc_error_o, end_bit_error_o, timeout_error_o, overrun_error_o};
        checks++;
        if (done_cnt !== dn || obs !== errs || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL %s status done=%0d errs=%b busy=%b exp done=%0d errs=%b busy=0",
                     name, done_cnt, obs, busy_o, dn, errs);
        end
    endtask

    task automatic test_reset;
        rst_ni = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        checks++;
        if ({push_o, busy_o, done_o, crc_error_o, end_bit_error_o, timeout_error_o,
             overrun_error_o} !== 7'b0 || push_data_o !== 32'h0) begin
            errors++;
            $display("FAIL reset outputs got=%b data=%08h exp=0", {push_o, busy_o, done_o,
                     crc_error_o, end_bit_error_o, timeout_error_o, overrun_error_o}, push_data_o);
        end
        rst_ni = 1'b1;
        @(posedge clk_i); #1;
    endtask

    task automatic test_zero_block;
        for (int i = 0; i < 8; i++) blk[i] = 8'h00;
        start_block(8, 1'b1, 1000);
        checks++;
        if (busy_o !== 1'b1) begin
            errors++;
            $display("FAIL zero_block busy got=%b exp=1", busy_o);
        end
        strobe(4'h0);
        for (int i = 0; i < 16; i++) strobe(4'h0);
        for (int i = 0; i < 16; i++) strobe(4'h0);
        strobe(4'hF);
        repeat (3) @(posedge clk_i);
        #1;
        check_words("zero_block", 8);
        check_status("zero_block", 1, 4'b0000);
        $display("zero_block: pushes=%0d done=%0d", got_q.size(), done_cnt);
    endtask

    task automatic test_byte_order;
        logic [7:0] pat [5] = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A};
        for (int i = 0; i < 5; i++) blk[i] = pat[i];
        run_block(5, 1'b1, 4'h0, 4'hF, 1'b0);
        check_words("byte_order", 5);
        checks++;
        if (got_q.size() == 2 && (got_q[0] !== 32'h78563412 || got_q[1] !== 32'h0000009A)) begin
            errors++;
            $display("FAIL byte_order words got=%08h,%08h exp=78563412,0000009a", got_q[0], got_q[1]);
        end
        check_status("byte_order", 1, 4'b0000);
        $display("byte_order: pushes=%0d", got_q.size());
    endtask

    task automatic test_random;
        int n;
        for (int it = 0; it < 6; it++) begin
            n = $urandom_range(1, 40);
            for (int i = 0; i < n; i++) blk[i] = 8'($urandom);
            run_block(n, 1'b1, 4'h0, 4'hF, 1'b0);
            check_words("random", n);
            check_status("random", 1, 4'b0000);
            $display("random: block %0d bytes=%0d pushes=%0d", it, n, got_q.size());
        end
    endtask

    task automatic test_errors;
        for (int i = 0; i < 8; i++) blk[i] = 8'h00;
        run_block(8, 1'b1, 4'b0100, 4'hF, 1'b0);
        check_words("crc_error", 8);
        check_status("crc_error", 1, 4'b1000);
        $display("crc_error: crc_error_o=%b", crc_error_o);
        for (int i = 0; i < 8; i++) blk[i] = 8'($urandom);
        run_block(8, 1'b1, 4'h0, 4'h7, 1'b0);
        repeat (4) @(posedge clk_i);
        #1;
        check_status("end_bit_error_held", 1, 4'b0100);
        $display("end_bit_error: end_bit_error_o=%b", end_bit_error_o);
    endtask

    task automatic test_timeout;
        start_block(8, 1'b1, 10);
        for (int i = 0; i < 9; i++) strobe(4'hF);
        checks++;
        if (done_cnt !== 0 || timeout_error_o !== 1'b0 || busy_o !== 1'b1) begin
            errors++;
            $display("FAIL timeout_early done=%0d to=%b busy=%b exp 0,0,1", done_cnt, timeout_error_o, busy_o);
        end
        strobe(4'hF);
        check_status("timeout", 1, 4'b0010);
        checks++;
        if (got_q.size() !== 0) begin
            errors++;
            $display("FAIL timeout pushes got=%0d exp=0", got_q.size());
        end
        $display("timeout: timeout_error_o=%b done=%0d", timeout_error_o, done_cnt);
    endtask

    task automatic test_zero_size;
        start_block(0, 1'b1, 1000);
        checks++;
        if (done_o !== 1'b1 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL zero_size done=%b busy=%b exp 1,0", done_o, busy_o);
        end
        @(posedge clk_i); #1;
        check_status("zero_size", 1, 4'b0000);
        $display("zero_size: done=%0d", done_cnt);
    endtask

    task automatic test_overrun;
        for (int i = 0; i < 8; i++) blk[i] = 8'($urandom);
        run_block(8, 1'b1, 4'h0, 4'hF, 1'b1);
        check_words("overrun", 4);
        check_status("overrun", 1, 4'b0001);
        $display("overrun: pushes=%0d overrun_error_o=%b", got_q.size(), overrun_error_o);
    endtask

    task automatic test_reset_mid;
        start_block(8, 1'b1, 1000);
        strobe(4'h0);
        for (int i = 0; i < 9; i++) strobe(4'($urandom));
        rst_ni = 1'b0;
        @(posedge clk_i); #1;
        checks++;
        if ({push_o, busy_o, done_o, crc_error_o, end_bit_error_o, timeout_error_o,
             overrun_error_o} !== 7'b0) begin
            errors++;
            $display("FAIL reset_mid outputs got=%b exp=0", {push_o, busy_o, done_o,
                     crc_error_o, end_bit_error_o, timeout_error_o, overrun_error_o});
        end
        rst_ni = 1'b1;
        for (int i = 0; i < 4; i++) blk[i] = 8'($urandom);
        run_block(4, 1'b1, 4'h0, 4'hF, 1'b0);
        check_words("after_reset", 4);
        check_status("after_reset", 1, 4'b0000);
        $display("reset_mid: recovery pushes=%0d", got_q.size());
    endtask

`ifdef SD_DAT_RX_1BIT_EN
    task automatic test_1bit;
        for (int i = 0; i < 512; i++) blk[i] = 8'hFF;
        run_block(512, 1'b0, 4'h0, 4'hF, 1'b0);
        check_words("1bit", 512);
        check_status("1bit", 1, 4'b0000);
        $display("1bit: pushes=%0d crc=%04h", got_q.size(), crc_line(512, 0, 1'b0));
        for (int i = 0; i < 512; i++) blk[i] = 8'hFF;
        run_block(512, 1'b0, 4'h1, 4'hF, 1'b0);
        check_status("1bit_crc_error", 1, 4'b1000);
        $display("1bit_crc_error: crc_error_o=%b", crc_error_o);
    endtask
`endif

    initial begin
        test_reset();
        test_zero_block();
        test_byte_order();
        test_random();
        test_errors();
        test_timeout();
        test_zero_size();
        test_overrun();
        test_reset_mid();
`ifdef SD_DAT_RX_1BIT_EN
        test_1bit();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
